run_detector: RTL and testbench
===============================

# run_detector

- Parametrised run-length detector: flags when the serial input has held the same value for at least RUN_LEN consecutive valid samples.
- Generalises the fixed four-in-a-row sequence detector:
  - configurable run length;
  - selectable match polarity;
  - sample-enable qualifier;
  - visible run count.
- Sits in the digital-experiment FSM lab designs, between a debounced switch/serial source and LED/segment display logic.
- Moore-style: all outputs are registered.

## Interface

Parameters:

- RUN_LEN, 4: number of consecutive identical samples required for detection; legal range 2..255.
- CNT_W, 8: width of run_cnt; must satisfy 2**CNT_W > RUN_LEN.
- MATCH, 0: polarity mode. 0 = runs of either value, 1 = runs of ones only, 2 = runs of zeros only.

Ports:

- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  sample qualifier. in is consumed only on edges where in_valid=1.
- in  in  1  serial input bit.
- out  out  1  detection flag.
- run_bit  out  1  value of the current run.
- run_cnt  out  CNT_W  length of the current run, saturating at RUN_LEN.
- state  out  2  current FSM state encoding.

## Operation

- States (encoding from package):
  - IDLE=0: no sample since reset.
  - RUN=1: run_cnt < RUN_LEN.
  - HIT=2: run_cnt == RUN_LEN.
  - Encoding 3 is illegal; it recovers to IDLE on the next edge.
- On a valid sample:
  - IDLE → RUN: run_bit<=in, run_cnt<=1.
  - RUN/HIT with in==run_bit: run_cnt<=min(run_cnt+1, RUN_LEN). Enter HIT when the new count reaches RUN_LEN; HIT stays HIT.
  - RUN/HIT with in!=run_bit: run_bit<=in, run_cnt<=1, state RUN.
- When in_valid=0, all registers hold.
- out = (state==HIT) and polarity qualifies:
  - MATCH=0: always qualifies.
  - MATCH=1: requires run_bit=1.
  - MATCH=2: requires run_bit=0.
- A run of the non-matching value still counts and still reaches HIT; out stays 0.
- Counter arithmetic is unsigned and saturates, so it never wraps. Runs of any length keep out high.

## Timing

- Reset values:
  - state=IDLE
  - run_cnt=0
  - run_bit=0
  - out=0
  - hit_cnt=0, when configured.
- Reset has priority over in_valid on the same edge.
- Reset mid-run discards the run; the next valid sample starts a fresh count of 1.
- Latency: out rises on the same edge that registers the RUN_LEN-th identical valid sample. It is visible in the following cycle; there is no combinational path from in to out.
- out falls on the edge that registers the first differing valid sample.
- Gaps in in_valid do not break a run.

## Configuration

- RUNDET_HIT_CNT_EN defined:
  - Adds output hit_cnt (16 bits).
  - Increments on each RUN→HIT transition where out becomes 1.
  - Saturates at 0xFFFF; cleared only by reset.
- RUNDET_HIT_CNT_EN undefined: port and logic are absent. All other behaviour is identical.

## Structure

- Package rundet_pkg holds:
  - the state enum (IDLE, RUN, HIT);
  - MATCH mode constants (MATCH_ANY, MATCH_ONES, MATCH_ZEROS);
  - the hit counter width constant.
- Sub-module sat_counter: an enable/load-to-1/saturating increment counter, parametrised by width and limit. It is reused for run_cnt and for hit_cnt.
- Parameter legality is checked by elaboration-time assertions.

## Test plan

- RUN_LEN=4, MATCH=0; in_valid=1; in=0,0,0,0,0,1 → out=0 until after the 4th sample; run_cnt 1,2,3,4,4,1; out returns to 0 after the 6th sample.
- RUN_LEN=4, MATCH=1; seven zeros then four ones → out stays 0 through the zeros (state=HIT, run_bit=0); out=1 after the 4th one.
- RUN_LEN=3; in=1 with in_valid pattern 1,0,0,1,0,1 → run_cnt 1,1,1,2,2,3; out=1 only after the 6th edge.
- Reset asserted while in HIT with run_cnt=4 → next cycle: state=IDLE, run_cnt=0, out=0. The first valid sample then gives run_cnt=1.
- RUN_LEN=5; alternating 0/1 for 20 samples → run_cnt stays 1 and out stays 0 throughout.
- RUNDET_HIT_CNT_EN defined; three separate runs of ones of length ≥ RUN_LEN separated by a zero → hit_cnt=3. Reset → hit_cnt=0.

Source files
------------

// File: rtl/rundet_pkg.sv
// Shared definitions for the run-length detector: state encoding, polarity
// modes and the hit counter width.
// Latency: n/a (definitions only).  Backpressure: n/a.
package rundet_pkg;

  // Encoding 3 is deliberately left unnamed; the FSM treats it as illegal.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2
  } state_e;

  localparam int MATCH_ANY   = 0;
  localparam int MATCH_ONES  = 1;
  localparam int MATCH_ZEROS = 2;

  localparam int HIT_CNT_W = 16;

  // True when a run of value run_bit may raise the detection flag.
  function automatic logic polarity_ok(input int match, input logic run_bit);
    case (match)
      MATCH_ONES:  return run_bit;
      MATCH_ZEROS: return !run_bit;
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/run_detector_sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-one.
// Latency: count updates on the edge after en/load1/clr.  Backpressure: none;
// en=0 holds the count.
//
// Ports:
//   clk, reset  clock, synchronous active-high reset (count -> 0)
//   clr         synchronous clear to 0 (highest priority after reset)
//   en          advance enable
//   load1       with en: load 1 instead of incrementing
//   cnt         registered count, never exceeds LIMIT
module sat_counter
  import rundet_pkg::*;
#(
  parameter int W     = 8,
  parameter int LIMIT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic         load1,
  output logic [W-1:0] cnt
);

  if (LIMIT < 1 || W < 1 || W > 31 || LIMIT > (2**W - 1)) begin : g_bad_limit
    $error("sat_counter: LIMIT must be in 1..2**W-1");
  end

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (load1) begin
        cnt_d = W'(1);
      end else if (cnt_q < LIM) begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/run_detector.sv
// Run-length detector: flags when the qualified serial input has held one
// value for at least RUN_LEN valid samples.
// Latency: all outputs registered, one edge after the qualifying sample.
// Backpressure: none; in_valid=0 freezes every register.
//
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   in_valid    sample qualifier; in is consumed only when high
//   in          serial input bit
//   out         detection flag (state HIT and polarity qualifies)
//   run_bit     value of the current run
//   run_cnt     length of current run, saturating at RUN_LEN
//   state       FSM state (IDLE=0, RUN=1, HIT=2)
//   hit_cnt     qualifying RUN->HIT transitions, saturating; present only
//               when RUNDET_HIT_CNT_EN is defined
module run_detector
  import rundet_pkg::*;
#(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8,
  parameter int MATCH   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in,
  output logic                 out,
  output logic                 run_bit,
  output logic [CNT_W-1:0]     run_cnt,
  output logic [1:0]           state
`ifdef RUNDET_HIT_CNT_EN
  ,
  output logic [HIT_CNT_W-1:0] hit_cnt
`endif
);

  if (RUN_LEN < 2 || RUN_LEN > 255) begin : g_bad_run_len
    $error("run_detector: RUN_LEN must be in 2..255");
  end
  if (CNT_W < 1 || CNT_W > 30 || (2**CNT_W) <= RUN_LEN) begin : g_bad_cnt_w
    $error("run_detector: CNT_W too narrow for RUN_LEN");
  end
  if (MATCH != MATCH_ANY && MATCH != MATCH_ONES && MATCH != MATCH_ZEROS) begin : g_bad_match
    $error("run_detector: MATCH must be 0, 1 or 2");
  end

  // Count value one below the target: an identical sample arriving here
  // completes the run.
  localparam logic [CNT_W-1:0] LAST_BEFORE_HIT = CNT_W'(RUN_LEN - 1);

  state_e           state_q, state_d;
  logic             run_bit_q, run_bit_d;
  logic             out_q, out_d;
  logic             cnt_en, cnt_load, cnt_clr;
  logic [CNT_W-1:0] run_cnt_q;

  always_comb begin
    state_d   = state_q;
    run_bit_d = run_bit_q;
    cnt_en    = 1'b0;
    cnt_load  = 1'b0;
    cnt_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d   = RUN;
          run_bit_d = in;
          cnt_en    = 1'b1;
          cnt_load  = 1'b1;
        end
      end
      RUN, HIT: begin
        if (in_valid) begin
          cnt_en = 1'b1;
          if (in != run_bit_q) begin
            state_d   = RUN;
            run_bit_d = in;
            cnt_load  = 1'b1;
          end else if (run_cnt_q >= LAST_BEFORE_HIT) begin
            // Covers both reaching the target and staying saturated in HIT.
            state_d = HIT;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: begin
        // Illegal encoding: drop whatever run was in progress.
        state_d   = IDLE;
        run_bit_d = 1'b0;
        cnt_clr   = 1'b1;
      end
    endcase
    out_d = (state_d == HIT) && polarity_ok(MATCH, run_bit_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      run_bit_q <= 1'b0;
      out_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_bit_q <= run_bit_d;
      out_q     <= out_d;
    end
  end

  sat_counter #(
    .W     (CNT_W),
    .LIMIT (RUN_LEN)
  ) u_run_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .load1 (cnt_load),
    .cnt   (run_cnt_q)
  );

`ifdef RUNDET_HIT_CNT_EN
  // Only entries into HIT that actually raise out are counted; a run of the
  // non-matching value reaching HIT is ignored.
  logic hit_inc;
  assign hit_inc = (state_q == RUN) && (state_d == HIT) && out_d;

  sat_counter #(
    .W     (HIT_CNT_W),
    .LIMIT ((2**HIT_CNT_W) - 1)
  ) u_hit_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .en    (hit_inc),
    .load1 (1'b0),
    .cnt   (hit_cnt)
  );
`endif

  assign out     = out_q;
  assign run_bit = run_bit_q;
  assign run_cnt = run_cnt_q;
  assign state   = state_q;

endmodule

// File: tb/tb_run_detector.sv
module tb_run_detector;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic in_valid = 1'b0;
  logic in_b     = 1'b0;

  always #5 clk = ~clk;

  // Three configurations share the same stimulus.
  int rl [3] = '{4, 3, 5};
  int mt [3] = '{0, 1, 2};

  logic       o_out [3];
  logic       o_rb  [3];
  logic [7:0] o_cnt [3];
  logic [1:0] o_st  [3];
`ifdef RUNDET_HIT_CNT_EN
  logic [15:0] o_hit [3];
`endif

  run_detector #(.RUN_LEN(4), .CNT_W(8), .MATCH(0)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_b),
    .out(o_out[0]), .run_bit(o_rb[0]), .run_cnt(o_cnt[0]), .state(o_st[0])
`ifdef RUNDET_HIT_CNT_EN
    , .hit_cnt(o_hit[0])
`endif
  );
  run_detector #(.RUN_LEN(3), .CNT_W(8), .MATCH(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_b),
    .out(o_out[1]), .run_bit(o_rb[1]), .run_cnt(o_cnt[1]), .state(o_st[1])
`ifdef RUNDET_HIT_CNT_EN
    , .hit_cnt(o_hit[1])
`endif
  );
  run_detector #(.RUN_LEN(5), .CNT_W(8), .MATCH(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_b),
    .out(o_out[2]), .run_bit(o_rb[2]), .run_cnt(o_cnt[2]), .state(o_st[2])
`ifdef RUNDET_HIT_CNT_EN
    , .hit_cnt(o_hit[2])
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  function automatic void chk(input string name, input int idx, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] @%0t: got %0d expected %0d", name, idx, $time, act, exp);
    end
  endfunction

  // Reference: track the true (unbounded) length of the current run.
  bit started [3];
  bit m_bit   [3];
  int m_len   [3];
  int m_hits  [3];

  function automatic bit qual(input int i, input bit b);
    return (mt[i] == 0) || (mt[i] == 1 && b) || (mt[i] == 2 && !b);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        started[i] = 1'b0;
        m_bit[i]   = 1'b0;
        m_len[i]   = 0;
        m_hits[i]  = 0;
      end else if (in_valid) begin
        if (!started[i] || in_b != m_bit[i]) begin
          started[i] = 1'b1;
          m_bit[i]   = in_b;
          m_len[i]   = 1;
        end else if (m_len[i] < 100000) begin
          m_len[i]++;
        end
        if (m_len[i] == rl[i] && qual(i, m_bit[i]) && m_hits[i] < 65535) m_hits[i]++;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        int e_cnt, e_st, e_out;
        e_cnt = !started[i] ? 0 : (m_len[i] < rl[i] ? m_len[i] : rl[i]);
        e_st  = !started[i] ? 0 : (m_len[i] >= rl[i] ? 2 : 1);
        e_out = (e_st == 2 && qual(i, m_bit[i])) ? 1 : 0;
        chk("model_run_cnt", i, int'(o_cnt[i]), e_cnt);
        chk("model_state",   i, int'(o_st[i]),  e_st);
        chk("model_run_bit", i, int'(o_rb[i]),  int'(m_bit[i]));
        chk("model_out",     i, int'(o_out[i]), e_out);
`ifdef RUNDET_HIT_CNT_EN
        chk("model_hit_cnt", i, int'(o_hit[i]), m_hits[i]);
`endif
      end
    end
  end

  // One clock: drive on the falling edge, return just after the rising edge.
  task automatic drive(input bit r, input bit v, input bit b);
    @(negedge clk);
    reset    = r;
    in_valid = v;
    in_b     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int exp_cnt1 [6] = '{1, 2, 3, 4, 4, 1};
    int exp_out1 [6] = '{0, 0, 0, 1, 1, 0};
    bit pat_v    [6] = '{1, 0, 0, 1, 0, 1};
    int exp_cnt3 [6] = '{1, 1, 1, 2, 2, 3};
    bit hit_seq  [14] = '{1, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1};
    bit prev;

    do_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk("rst_state",   i, int'(o_st[i]),  0);
      chk("rst_run_cnt", i, int'(o_cnt[i]), 0);
      chk("rst_run_bit", i, int'(o_rb[i]),  0);
      chk("rst_out",     i, int'(o_out[i]), 0);
    end
    cmp_en = 1'b1;

    // Five zeros then a one on RUN_LEN=4, MATCH any.
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b1, (k == 5));
      chk("seq_run_cnt", 0, int'(o_cnt[0]), exp_cnt1[k]);
      chk("seq_out",     0, int'(o_out[0]), exp_out1[k]);
    end

    // Reset while in HIT.
    do_reset();
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 1'b0);
    chk("pre_rst_state", 0, int'(o_st[0]), 2);
    drive(1'b1, 1'b1, 1'b0);
    chk("hit_rst_state", 0, int'(o_st[0]),  0);
    chk("hit_rst_cnt",   0, int'(o_cnt[0]), 0);
    chk("hit_rst_out",   0, int'(o_out[0]), 0);
    drive(1'b0, 1'b1, 1'b1);
    chk("post_rst_cnt",  0, int'(o_cnt[0]), 1);

    // MATCH ones: zeros reach HIT but never flag.
    do_reset();
    for (int k = 0; k < 7; k++) drive(1'b0, 1'b1, 1'b0);
    chk("zeros_state", 1, int'(o_st[1]),  2);
    chk("zeros_rbit",  1, int'(o_rb[1]),  0);
    chk("zeros_out",   1, int'(o_out[1]), 0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b1);
      chk("ones_out", 1, int'(o_out[1]), (k == 2) ? 1 : 0);
    end

    // Gaps in in_valid do not break a run.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, pat_v[k], 1'b1);
      chk("gap_run_cnt", 1, int'(o_cnt[1]), exp_cnt3[k]);
      chk("gap_out",     1, int'(o_out[1]), (k == 5) ? 1 : 0);
    end

    // Alternating input never builds a run.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b1, k[0]);
      chk("alt_run_cnt", 2, int'(o_cnt[2]), 1);
      chk("alt_out",     2, int'(o_out[2]), 0);
    end

    // Three separate runs of ones, each long enough for RUN_LEN=3.
    do_reset();
    for (int k = 0; k < 14; k++) drive(1'b0, 1'b1, hit_seq[k]);
`ifdef RUNDET_HIT_CNT_EN
    chk("hit_cnt_three", 1, int'(o_hit[1]), 3);
    do_reset();
    chk("hit_cnt_rst",   1, int'(o_hit[1]), 0);
`else
    chk("runs_out", 1, int'(o_out[1]), 1);
`endif

    // Random phase: sticky input so runs of all lengths occur.
    prev = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      bit r, v, b;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 4) == 0) ? ~prev : prev;
      prev = b;
      drive(r, v, b);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
